// File: rtl/gpr_pkg.sv
// gpr_pkg: shared constants and types for the GPR writeback path
package gpr_pkg;
   localparam int NREG = 32;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int STARVE_LIM = 4;
   localparam int CW = $clog2(STARVE_LIM + 1);
   typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_LSU, SRC_MDU} wb_src_e;
endpackage

// File: rtl/gpr_writeback_if.sv
// gpr_writeback_if: producer handshakes, issue port and register file write port
// master: the writeback block (drives readies, write port, busy, sb_err)
// slave: the surrounding pipeline (drives results and issue)
interface gpr_writeback_if;
   import gpr_pkg::*;
   logic            alu_valid;
   logic [AW-1:0]   alu_rd;
   logic [DW-1:0]   alu_data;
   logic            lsu_valid;
   logic            lsu_ready;
   logic [AW-1:0]   lsu_rd;
   logic [DW-1:0]   lsu_data;
   logic            mdu_valid;
   logic            mdu_ready;
   logic [AW-1:0]   mdu_rd;
   logic [DW-1:0]   mdu_data;
   logic            issue_valid;
   logic [AW-1:0]   issue_rd;
   logic [AW-1:0]   gpr_write;
   logic [DW-1:0]   gpr_write_data;
   logic            gpr_wd;
   logic [NREG-1:0] busy;
   logic            sb_err;
   modport master (
      input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
             mdu_valid, mdu_rd, mdu_data, issue_valid, issue_rd,
      output lsu_ready, mdu_ready, gpr_write, gpr_write_data, gpr_wd, busy, sb_err
   );
   modport slave (
      output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
             mdu_valid, mdu_rd, mdu_data, issue_valid, issue_rd,
      input  lsu_ready, mdu_ready, gpr_write, gpr_write_data, gpr_wd, busy, sb_err
   );
endinterface

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: pending-write bitmap for long-latency results
// set_valid/set_idx: mark register pending; clr_valid/clr_idx: result written
// busy: pending bitmap (bit 0 never set); sb_err: sticky double-issue flag
module gpr_scoreboard
   import gpr_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            set_valid,
   input  logic [AW-1:0]   set_idx,
   input  logic            clr_valid,
   input  logic [AW-1:0]   clr_idx,
   output logic [NREG-1:0] busy,
   output logic            sb_err
);
   logic [NREG-1:0] set_mask, clr_mask;
   always_comb begin
      set_mask = (set_valid && set_idx != '0) ? NREG'(1) << set_idx : '0;
      clr_mask = (clr_valid && clr_idx != '0) ? NREG'(1) << clr_idx : '0;
   end
   // set is applied after clear so a same-index collision leaves the bit set
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         busy   <= '0;
         sb_err <= 1'b0;
      end else begin
         busy   <= (busy & ~clr_mask) | set_mask;
         sb_err <= sb_err | (|(set_mask & busy & ~clr_mask));
      end
endmodule

// File: rtl/gpr_writeback.sv
// gpr_writeback: arbitrates ALU/LSU/MDU results onto the register file write port
// clk, rst_n: clock and asynchronous active-low reset
// wb: producer handshakes, issue port, registered write port, busy bitmap, sb_err
module gpr_writeback
   import gpr_pkg::*;
(
   input logic             clk,
   input logic             rst_n,
   gpr_writeback_if.master wb
);
   wb_src_e       src;
   logic          starved;
   logic          wr_en;
   logic          clr_valid;
   logic [CW-1:0] wait_cnt;
   logic [AW-1:0] sel_rd;
   logic [DW-1:0] sel_data;
   // readies are gated by rst_n so nothing is accepted while in reset
   always_comb begin
      starved      = wait_cnt == CW'(STARVE_LIM);
      wb.lsu_ready = rst_n && !wb.alu_valid && !(wb.mdu_valid && starved);
      wb.mdu_ready = rst_n && !wb.alu_valid && (!wb.lsu_valid || starved);
      src          = wb.alu_valid ? SRC_ALU :
                     (wb.lsu_valid && wb.lsu_ready) ? SRC_LSU :
                     (wb.mdu_valid && wb.mdu_ready) ? SRC_MDU : SRC_NONE;
      sel_rd       = src == SRC_ALU ? wb.alu_rd : src == SRC_LSU ? wb.lsu_rd : wb.mdu_rd;
      sel_data     = src == SRC_ALU ? wb.alu_data : src == SRC_LSU ? wb.lsu_data : wb.mdu_data;
      wr_en        = src != SRC_NONE && sel_rd != '0;
      clr_valid    = (src == SRC_LSU || src == SRC_MDU) && sel_rd != '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wb.gpr_wd         <= 1'b0;
         wb.gpr_write      <= '0;
         wb.gpr_write_data <= '0;
         wait_cnt          <= '0;
      end else begin
         wb.gpr_wd <= wr_en;
         if (wr_en) begin
            wb.gpr_write      <= sel_rd;
            wb.gpr_write_data <= sel_data;
         end
         if (wb.mdu_valid)
            wait_cnt <= wb.mdu_ready ? '0 : starved ? wait_cnt : wait_cnt + CW'(1);
      end
   gpr_scoreboard u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_valid (wb.issue_valid),
      .set_idx   (wb.issue_rd),
      .clr_valid (clr_valid),
      .clr_idx   (sel_rd),
      .busy      (wb.busy),
      .sb_err    (wb.sb_err)
   );
endmodule

// File: tb/tb_gpr_writeback.sv
// tb_gpr_writeback: directed and randomized checks of gpr_writeback against a reference model
module tb_gpr_writeback;
   import gpr_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_cmp = 0;
   int n_err = 0;
   gpr_writeback_if wb();
   gpr_writeback u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (wb)
   );
   always #5 clk = ~clk;
   logic [31:0] m_busy;
   bit          m_err;
   int          m_wcnt;
   bit          m_wd;
   int          m_wr;
   logic [31:0] m_wdata;
   bit          m_acc_l;
   bit          m_acc_m;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_cmp++;
      if (obs !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, obs, req, $time);
      end
   endtask
   task automatic model_reset();
      m_busy = '0;
      m_err = 0;
      m_wcnt = 0;
      m_wd = 0;
      m_wr = 0;
      m_wdata = '0;
      m_acc_l = 0;
      m_acc_m = 0;
   endtask
   task automatic drive(input bit av, input int ar, input logic [31:0] ad,
                        input bit lv, input int lr, input logic [31:0] ld,
                        input bit mv, input int mr, input logic [31:0] md,
                        input bit iv, input int ir);
      wb.alu_valid = av; wb.alu_rd = AW'(ar); wb.alu_data = ad;
      wb.lsu_valid = lv; wb.lsu_rd = AW'(lr); wb.lsu_data = ld;
      wb.mdu_valid = mv; wb.mdu_rd = AW'(mr); wb.mdu_data = md;
      wb.issue_valid = iv; wb.issue_rd = AW'(ir);
   endtask
   // one clock: check readies against the arbitration rules, predict the edge, check outputs after it
   task automatic cycle();
      bit st, rl, rm;
      int rd, clr;
      logic [31:0] d;
      bit any;
      #1;
      st = m_wcnt >= STARVE_LIM;
      rl = !wb.alu_valid && !(wb.mdu_valid && st);
      rm = !wb.alu_valid && (!wb.lsu_valid || st);
      chk("lsu_ready", wb.lsu_ready, rl);
      chk("mdu_ready", wb.mdu_ready, rm);
      m_acc_l = wb.lsu_valid && rl;
      m_acc_m = wb.mdu_valid && rm && !m_acc_l;
      any = 1; rd = 0; d = '0;
      if (wb.alu_valid) begin rd = int'(wb.alu_rd); d = wb.alu_data; end
      else if (m_acc_l) begin rd = int'(wb.lsu_rd); d = wb.lsu_data; end
      else if (m_acc_m) begin rd = int'(wb.mdu_rd); d = wb.mdu_data; end
      else any = 0;
      m_wd = any && rd != 0;
      if (m_wd) begin m_wr = rd; m_wdata = d; end
      clr = ((m_acc_l || m_acc_m) && rd != 0) ? rd : -1;
      if (wb.issue_valid && wb.issue_rd != 0 && m_busy[wb.issue_rd] && int'(wb.issue_rd) != clr) m_err = 1;
      if (clr > 0) m_busy[clr] = 1'b0;
      if (wb.issue_valid && wb.issue_rd != 0) m_busy[wb.issue_rd] = 1'b1;
      if (wb.mdu_valid) m_wcnt = m_acc_m ? 0 : (m_wcnt < STARVE_LIM ? m_wcnt + 1 : STARVE_LIM);
      @(posedge clk);
      #1;
      chk("gpr_wd", wb.gpr_wd, m_wd);
      chk("busy", wb.busy, m_busy);
      chk("sb_err", wb.sb_err, m_err);
      if (m_wd) begin
         chk("gpr_write", wb.gpr_write, m_wr);
         chk("gpr_write_data", wb.gpr_write_data, m_wdata);
      end
   endtask
   bit l_v, m_v, a_v, i_v;
   int l_r, m_r, a_r, i_r;
   logic [31:0] l_d, m_d, a_d;
   initial begin
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wd", wb.gpr_wd, 0);
      chk("rst_write", wb.gpr_write, 0);
      chk("rst_data", wb.gpr_write_data, 0);
      chk("rst_busy", wb.busy, 0);
      chk("rst_sb_err", wb.sb_err, 0);
      rst_n = 1'b1;
      drive(1, 3, 32'h1234_5678, 1, 1, 32'hDEAD_0001, 0, 0, 0, 0, 0);
      #1 chk("tp1_lsu_rdy", wb.lsu_ready, 0);
      cycle();
      chk("tp1_wd", wb.gpr_wd, 1);
      chk("tp1_write", wb.gpr_write, 3);
      chk("tp1_data", wb.gpr_write_data, 32'h1234_5678);
      drive(0, 0, 0, 1, 1, 32'hDEAD_0001, 0, 0, 0, 0, 0);
      cycle();
      drive(0, 0, 0, 1, 5, 32'hA5A5_0000, 1, 6, 32'h6666_0006, 0, 0);
      cycle();
      chk("tp2_first", wb.gpr_write, 5);
      drive(0, 0, 0, 0, 0, 0, 1, 6, 32'h6666_0006, 0, 0);
      cycle();
      chk("tp2_second_wd", wb.gpr_wd, 1);
      chk("tp2_second", wb.gpr_write, 6);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("hold_wd", wb.gpr_wd, 0);
      chk("hold_write", wb.gpr_write, 6);
      chk("hold_data", wb.gpr_write_data, 32'h6666_0006);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 1, 8, 32'h8888_0000, 1, 7, 32'h7777_0007, 0, 0);
         #1;
         chk("tp3_mdu_rdy", wb.mdu_ready, i == 4);
         chk("tp3_lsu_rdy", wb.lsu_ready, i != 4);
         cycle();
      end
      chk("tp3_mdu_write", wb.gpr_write, 7);
      drive(0, 0, 0, 1, 8, 32'h8888_0000, 1, 10, 32'hAAAA_000A, 0, 0);
      #1 chk("tp3_cnt_cleared", wb.mdu_ready, 0);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 1, 10, 32'hAAAA_000A, 0, 0);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
      cycle();
      chk("tp4_busy9_set", wb.busy[9], 1);
      drive(0, 0, 0, 0, 0, 0, 1, 9, 32'h9999_0009, 0, 0);
      cycle();
      chk("tp4_busy9_clr", wb.busy[9], 0);
      chk("tp4_wd", wb.gpr_wd, 1);
      chk("tp4_write", wb.gpr_write, 9);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
      cycle();
      drive(0, 0, 0, 1, 9, 32'h5555_0009, 0, 0, 0, 1, 9);
      cycle();
      chk("tp5_set_wins", wb.busy[9], 1);
      chk("tp5_no_err", wb.sb_err, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
      cycle();
      chk("tp5_err", wb.sb_err, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      cycle();
      chk("tp5_err_sticky", wb.sb_err, 1);
      drive(0, 0, 0, 1, 0, 32'h0BAD_0000, 0, 0, 0, 0, 0);
      #1 chk("tp6_rd0_rdy", wb.lsu_ready, 1);
      cycle();
      chk("tp6_rd0_wd", wb.gpr_wd, 0);
      chk("tp6_rd0_busy", wb.busy, 32'h0000_0200);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
      cycle();
      drive(1, 2, 32'h2222_0002, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("tp6_pre_busy", wb.busy, 32'h0000_0210);
      chk("tp6_pre_wd", wb.gpr_wd, 1);
      drive(0, 0, 0, 1, 3, 32'h3, 1, 4, 32'h4, 0, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("tp6_async_busy", wb.busy, 0);
      chk("tp6_async_wd", wb.gpr_wd, 0);
      chk("tp6_async_err", wb.sb_err, 0);
      chk("tp6_rst_lsu_rdy", wb.lsu_ready, 0);
      chk("tp6_rst_mdu_rdy", wb.mdu_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("tp6_rst_hold_wd", wb.gpr_wd, 0);
      model_reset();
      rst_n = 1'b1;
      l_v = 0; m_v = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!l_v || m_acc_l) begin
            l_v = $urandom_range(0, 1) == 1;
            l_r = $urandom_range(0, 31);
            l_d = $urandom;
         end
         if (!m_v || m_acc_m) begin
            m_v = $urandom_range(0, 2) != 0;
            m_r = $urandom_range(0, 31);
            m_d = $urandom;
         end
         a_v = $urandom_range(0, 3) == 0;
         a_r = $urandom_range(0, 31);
         a_d = $urandom;
         i_v = $urandom_range(0, 3) == 0;
         i_r = $urandom_range(0, 31);
         drive(a_v, a_r, a_d, l_v, l_r, l_d, m_v, m_r, m_d, i_v, i_r);
         cycle();
         if (n == 1500) begin
            rst_n = 1'b0;
            #1 chk("rnd_rst_busy", wb.busy, 0);
            @(posedge clk);
            #1;
            model_reset();
            l_v = 0; m_v = 0;
            rst_n = 1'b1;
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/gpr_writeback.md
Name: gpr_writeback

Overview:
- Initiator side of the general-purpose register file write port.
- Collects results from three producers and serialises them onto the single register write port (`write`/`write_data`/`wd`), at most one write per clock:
  - ALU: single-cycle, no backpressure.
  - LSU: load data, valid/ready.
  - MDU: multiply/divide, valid/ready.
- Keeps a pending-write scoreboard so the decode stage can stall on RAW hazards against outstanding long-latency ops.

Parameters:
- NREG, 32, number of architectural registers.
- AW, 5, register index width (log2 NREG).
- DW, 32, data width.
- STARVE_LIM, 4, consecutive refused MDU cycles before MDU outranks LSU.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result present this cycle (always accepted)
- alu_rd  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- lsu_valid  in  1  load result offered
- lsu_ready  out  1  load result accepted this cycle
- lsu_rd  in  AW  load destination
- lsu_data  in  DW  load data
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  MDU result accepted this cycle
- mdu_rd  in  AW  MDU destination
- mdu_data  in  DW  MDU result
- issue_valid  in  1  decode issues an LSU/MDU op this cycle
- issue_rd  in  AW  destination of issued op
- gpr_write  out  AW  register file write index
- gpr_write_data  out  DW  register file write data
- gpr_wd  out  1  register file write enable
- busy  out  NREG  pending-write bitmap, bit i = register i awaits LSU/MDU result
- sb_err  out  1  sticky: issue to an already-busy register

Behaviour:
- Reset (rst_n low, asynchronous):
  - gpr_wd=0, gpr_write=0, gpr_write_data=0.
  - busy=0, sb_err=0, starvation counter=0.
  - Reset mid-operation discards all pending state; results offered during reset are not accepted.
- Arbitration is combinational within the cycle. Fixed priority ALU > LSU > MDU, except as noted:
  - lsu_ready = !alu_valid && !(mdu_valid && starved).
  - mdu_ready = !alu_valid && (!lsu_valid || starved).
  - starved = (wait_cnt == STARVE_LIM).
- Starvation counter wait_cnt (width clog2(STARVE_LIM+1)):
  - Increments, saturating at STARVE_LIM, on each cycle with mdu_valid && !mdu_ready.
  - Clears to 0 on MDU acceptance.
  - Holds when mdu_valid is low.
- Valid/ready rules:
  - A transfer occurs when valid && ready.
  - Producers hold valid, rd and data stable until accepted; the block does not check this.
- Write port is registered, latency 1:
  - A result accepted in cycle N drives gpr_wd=1 with gpr_write/gpr_write_data in cycle N+1.
  - No accept in cycle N gives gpr_wd=0 in N+1, with gpr_write/gpr_write_data holding their last values.
- rd == 0:
  - The result is accepted (ready behaves normally) but gpr_wd stays 0.
  - A busy bit is never set or cleared for register 0.
- Scoreboard:
  - issue_valid with issue_rd != 0 sets busy[issue_rd] at the next edge.
  - An accepted LSU or MDU transfer with rd != 0 clears busy[rd] at the next edge (same edge gpr_wd rises).
  - ALU writes never touch busy.
  - Simultaneous set and clear of the same index: set wins.
  - Issue to an index whose busy bit is already 1 (and not being cleared that cycle) sets sb_err; it stays 1 until reset.
- ALU asserted every cycle starves LSU and MDU indefinitely. Preventing this is the pipeline's obligation, not this block's.

Decomposition:
- Shared package gpr_pkg:
  - Constants NREG, AW, DW.
  - Enum wb_src_e {SRC_NONE, SRC_ALU, SRC_LSU, SRC_MDU} for the arbiter select and debug.
- Sub-module gpr_scoreboard:
  - Inputs: set_valid/set_idx, clr_valid/clr_idx.
  - Outputs: busy bitmap, sb_err.
  - The arbiter and output register stay in the top.

Test Plan:
- Reset release, then alu_valid=1, alu_rd=3, alu_data=32'h1234_5678 → next cycle gpr_wd=1, gpr_write=3, gpr_write_data=32'h1234_5678; lsu_ready=0 during that cycle.
- LSU (rd=5, 32'hA5A5_0000) and MDU (rd=6) valid together with no ALU → LSU written first, MDU accepted the next cycle; two consecutive gpr_wd pulses in order 5 then 6.
- LSU valid continuously, MDU valid (rd=7) → mdu_ready stays 0 for 4 cycles, then goes 1 on the 5th cycle while lsu_ready=0; wait_cnt returns to 0.
- issue_valid with issue_rd=9 → busy[9]=1 next cycle; later MDU rd=9 accepted → busy[9]=0 on the same edge gpr_wd=1 with gpr_write=9.
- Same cycle: issue_rd=9 and LSU rd=9 accepted → busy[9] remains 1. Second issue to rd=9 while busy → sb_err=1 and sticky.
- LSU rd=0 accepted → lsu_ready=1, gpr_wd stays 0, busy unchanged. Assert rst_n low mid-stream with busy=32'h0000_0210 → busy=0 and gpr_wd=0 immediately, without waiting for a clock edge.
